// File: rtl/pipe_scheduler.sv
// Pipe-field sequencer for the 16x16 LED game: paces left shifts of the pipe field,
// builds the column entering at the right edge, and tightens the pace as pipes spawn.
module pipe_scheduler #(
    parameter int unsigned TICK_DIV    = 16,
    parameter int unsigned TICK_MIN    = 4,
    parameter int unsigned TICK_STEP   = 2,
    parameter int unsigned LEVEL_PIPES = 8,
    parameter int unsigned PIPE_W      = 2,
    parameter int unsigned SPACING     = 6,
    parameter int unsigned GAP_H       = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        go,
    input  logic        Over,
    output logic        shift,
    output logic [15:0] newCol,
    output logic        spawn,
    output logic [3:0]  gapTop,
    output logic [3:0]  level,
    output logic        running
);
    localparam int unsigned TW   = $clog2(TICK_DIV + 1);
    localparam int unsigned NCOL = PIPE_W + SPACING;
    localparam int unsigned CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int unsigned PCW  = (LEVEL_PIPES > 1) ? $clog2(LEVEL_PIPES) : 1;

    localparam logic [TW-1:0]  PERIOD_INIT = TW'(TICK_DIV);
    localparam logic [TW-1:0]  PERIOD_MIN  = TW'(TICK_MIN);
    localparam logic [TW-1:0]  PERIOD_STEP = TW'(TICK_STEP);
    localparam logic [CW-1:0]  COL_LAST    = CW'(NCOL - 1);
    localparam logic [CW-1:0]  COL_PIPE    = CW'(PIPE_W);
    localparam logic [PCW-1:0] PIPES_LAST  = PCW'(LEVEL_PIPES - 1);
    localparam logic [3:0]     GAP_LIMIT   = 4'(16 - GAP_H);
    localparam logic [15:0]    GAP_MASK    = 16'((32'd1 << GAP_H) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t         state;
    logic [7:0]     lfsr;
    logic           lfsr_fb;
    logic [TW-1:0]  tick;
    logic [TW-1:0]  period;
    logic [TW-1:0]  period_next;
    logic [CW-1:0]  col;
    logic [PCW-1:0] pipes;
    logic [3:0]     gap_new;
    logic [3:0]     gap_sel;

    always_comb begin
        lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        // Gaps that would run off the bottom row fold back up by 8 rows.
        gap_new = (lfsr[3:0] > GAP_LIMIT) ? lfsr[3:0] - 4'd8 : lfsr[3:0];
        gap_sel = (col == '0) ? gap_new : gapTop;
        period_next = (32'(period) < TICK_MIN + TICK_STEP) ? PERIOD_MIN
                                                           : period - PERIOD_STEP;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= IDLE;
            lfsr    <= 8'hA5;
            tick    <= '0;
            period  <= PERIOD_INIT;
            col     <= '0;
            pipes   <= '0;
            shift   <= 1'b0;
            spawn   <= 1'b0;
            newCol  <= '0;
            gapTop  <= '0;
            level   <= '0;
            running <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr_fb};
            shift <= 1'b0;
            spawn <= 1'b0;
            case (state)
                IDLE: begin
                    if (Over) begin
                        state   <= OVER;
                        running <= 1'b0;
                    end else if (go) begin
                        state   <= RUN;
                        running <= 1'b1;
                        tick    <= '0;
                        col     <= '0;
                    end
                end
                RUN: begin
                    // Over takes priority over a coinciding tick wrap, so no shift leaks out.
                    if (Over) begin
                        state   <= OVER;
                        running <= 1'b0;
                    end else if (tick == period - TW'(1)) begin
                        tick   <= '0;
                        shift  <= 1'b1;
                        newCol <= (col < COL_PIPE) ? ~(GAP_MASK << gap_sel) : '0;
                        col    <= (col == COL_LAST) ? '0 : col + CW'(1);
                        if (col == '0) begin
                            gapTop <= gap_new;
                            spawn  <= 1'b1;
                            if (pipes == PIPES_LAST) begin
                                pipes  <= '0;
                                period <= period_next;
                                if (level != 4'hF) level <= level + 4'd1;
                            end else begin
                                pipes <= pipes + PCW'(1);
                            end
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                default: begin
                    running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench for pipe_scheduler: a cycle model queues expected shift columns,
// a negedge monitor pops them; directed phases add hand-computed timing/level checks.
module tb_pipe_scheduler;
    localparam int TD = 8, TM = 4, TS = 2, LP = 2, PW = 2, SP = 6, GH = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        go = 1'b0;
    logic        Over = 1'b0;
    logic        shift;
    logic [15:0] newCol;
    logic        spawn;
    logic [3:0]  gapTop;
    logic [3:0]  level;
    logic        running;

    pipe_scheduler #(
        .TICK_DIV(TD), .TICK_MIN(TM), .TICK_STEP(TS), .LEVEL_PIPES(LP),
        .PIPE_W(PW), .SPACING(SP), .GAP_H(GH)
    ) dut (
        .clk(clk), .RST(RST), .go(go), .Over(Over), .shift(shift), .newCol(newCol),
        .spawn(spawn), .gapTop(gapTop), .level(level), .running(running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] col;
        logic        spawn;
        logic [3:0]  gap;
        logic [3:0]  lvl;
    } exp_t;
    exp_t q[$];

    // Reference model, advanced on every rising edge with the inputs seen at that edge.
    int          m_state = 0;   // 0 idle, 1 run, 2 over
    int          m_tick, m_period, m_col, m_pipes, m_level;
    logic [7:0]  m_lfsr;
    logic [3:0]  m_gap;
    exp_t        m_e;
    always @(posedge clk) begin
        if (RST) begin
            m_state = 0; m_tick = 0; m_period = TD; m_col = 0; m_pipes = 0;
            m_level = 0; m_lfsr = 8'hA5; m_gap = 4'd0;
        end else begin
            if (m_state == 0) begin
                if (Over) m_state = 2;
                else if (go) begin m_state = 1; m_tick = 0; m_col = 0; end
            end else if (m_state == 1) begin
                if (Over) m_state = 2;
                else if (m_tick == m_period - 1) begin
                    m_tick = 0;
                    m_e.spawn = (m_col == 0);
                    if (m_col == 0) begin
                        m_gap = m_lfsr[3:0];
                        if (m_gap > 4'd12) m_gap = m_gap - 4'd8;
                        m_pipes++;
                        if (m_pipes == LP) begin
                            m_pipes = 0;
                            if (m_level < 15) m_level++;
                            m_period = (m_period - TS < TM) ? TM : m_period - TS;
                        end
                    end
                    m_e.col = (m_col < PW) ? ~(16'hF << m_gap) : 16'h0000;
                    m_e.gap = m_gap;
                    m_e.lvl = 4'(m_level);
                    q.push_back(m_e);
                    m_col = (m_col + 1) % (PW + SP);
                end else m_tick++;
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Monitor: records every shift and compares it with the scoreboard head.
    int          sh_cyc[$];
    logic [15:0] sh_col[$];
    logic        sh_spawn[$];
    logic [3:0]  spawn_lvl[$];
    exp_t        e;
    logic [15:0] pat;
    always @(negedge clk) begin
        if (shift) begin
            if (q.size() == 0) check("unexpected_shift", 1, 0);
            else begin
                e = q.pop_front();
                check("newCol", newCol, e.col);
                check("spawn", spawn, e.spawn);
                check("gapTop", gapTop, e.gap);
                check("level", level, e.lvl);
            end
            sh_cyc.push_back(cyc);
            sh_col.push_back(newCol);
            sh_spawn.push_back(spawn);
            if (spawn) begin
                spawn_lvl.push_back(level);
                pat = ~(16'hF << gapTop);
                check("gap_bound", gapTop <= 4'd12, 1);
                check("gap_zero_count", $countones(~newCol), GH);
                check("gap_contiguous", newCol, pat);
            end
        end else begin
            if (q.size() != 0) begin
                check("missing_shift", 0, 1);
                q.delete();
            end
            if (spawn) check("spawn_without_shift", 1, 0);
        end
        check("running", running, m_state == 1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        sh_cyc.delete(); sh_col.delete(); sh_spawn.delete(); spawn_lvl.delete();
    endtask

    task automatic wait_shifts(input int n, input int budget, input string name);
        int k = 0;
        while (sh_cyc.size() < n && k < budget) begin step(1); k++; end
        if (sh_cyc.size() < n) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_spawns(input int n, input int budget, input string name);
        int k = 0;
        while (spawn_lvl.size() < n && k < budget) begin step(1); k++; end
        if (spawn_lvl.size() < n) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_shift"}, shift, 0);
        check({tag, "_spawn"}, spawn, 0);
        check({tag, "_newCol"}, newCol, 0);
        check({tag, "_gapTop"}, gapTop, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_running"}, running, 0);
    endtask

    int e0;
    int n0;
    int k;
    logic [15:0] last_col;

    initial begin
        // Reset, then idle with go low.
        RST = 1'b1; step(2); RST = 1'b0;
        check_reset_outputs("reset");
        clear_log();
        step(50);
        check("idle_no_shift", sh_cyc.size(), 0);
        check_reset_outputs("idle");

        // Run until 64 pipes have spawned.
        go = 1'b1; step(1); e0 = cyc; go = 1'b0;
        check("running_after_go", running, 1);
        wait_spawns(64, 6000, "spawn64");
        if (sh_cyc.size() >= 42 && spawn_lvl.size() >= 64) begin
            check("first_shift_latency", sh_cyc[0] - e0, 8);
            check("spacing_1_2", sh_cyc[1] - sh_cyc[0], 8);
            check("spacing_8_9", sh_cyc[8] - sh_cyc[7], 8);
            check("spacing_9_10", sh_cyc[9] - sh_cyc[8], 6);
            check("spacing_17_18", sh_cyc[17] - sh_cyc[16], 6);
            check("spacing_25_26", sh_cyc[25] - sh_cyc[24], 4);
            check("spacing_41_42", sh_cyc[41] - sh_cyc[40], 4);
            check("spawn_on_shift1", sh_spawn[0], 1);
            check("no_spawn_shift2", sh_spawn[1], 0);
            check("no_spawn_shift8", sh_spawn[7], 0);
            check("spawn_on_shift9", sh_spawn[8], 1);
            check("spawn_on_shift17", sh_spawn[16], 1);
            check("pipe_cols_equal", sh_col[1], sh_col[0]);
            check("sky_shift3", sh_col[2], 16'h0000);
            check("sky_shift8", sh_col[7], 16'h0000);
            check("level_at_spawn1", spawn_lvl[0], 0);
            check("level_at_spawn2", spawn_lvl[1], 1);
            check("level_at_spawn6", spawn_lvl[5], 3);
            check("level_at_spawn64", spawn_lvl[63], 15);
        end

        // Over coinciding with a tick wrap.
        k = 0;
        while (!(m_state == 1 && m_tick == m_period - 1) && k < 20) begin step(1); k++; end
        check("found_wrap", k < 20, 1);
        last_col = newCol;
        n0 = sh_cyc.size();
        Over = 1'b1; step(1); Over = 1'b0;
        check("over_running", running, 0);
        check("over_shift", shift, 0);
        for (int i = 0; i < 100; i++) begin
            go = (i % 25 == 3);
            step(1);
            check("over_newCol_hold", newCol, last_col);
        end
        go = 1'b0;
        check("over_no_shift", sh_cyc.size() - n0, 0);
        check("over_level_hold", level, 15);
        RST = 1'b1; step(1); RST = 1'b0;
        check_reset_outputs("rst_from_over");

        // go and Over together in IDLE.
        clear_log();
        go = 1'b1; Over = 1'b1; step(1); go = 1'b0; Over = 1'b0;
        step(50);
        check("go_over_no_shift", sh_cyc.size(), 0);
        check("go_over_running", running, 0);
        RST = 1'b1; step(1); RST = 1'b0;

        // Reset mid-run after the period has shortened, then restart.
        clear_log();
        go = 1'b1; step(1); go = 1'b0;
        wait_spawns(4, 400, "spawn4");
        step(3);
        RST = 1'b1; step(1); RST = 1'b0;
        check_reset_outputs("rst_mid_run");
        clear_log();
        step(20);
        check("post_rst_idle", sh_cyc.size(), 0);
        go = 1'b1; step(1); e0 = cyc; go = 1'b0;
        wait_shifts(2, 100, "restart");
        if (sh_cyc.size() >= 2) begin
            check("restart_latency", sh_cyc[0] - e0, 8);
            check("restart_spacing", sh_cyc[1] - sh_cyc[0], 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequencer for the scrolling green pipe field on the 16x16 LED matrix. It decides when the pipe field shifts one column left, generates the 16-bit column pattern injected at the right edge (a pipe with a pseudo-random gap, or empty sky), and shortens the shift period as more pipes spawn. It sits between the game-state logic (go/Over) and the green pipe shift register, which loads `newCol` on every cycle where `shift` is high.

## Interface
- `TICK_DIV`, default 16: initial clk cycles per shift (≥ 2).
- `TICK_MIN`, default 4: minimum shift period (2 ≤ TICK_MIN ≤ TICK_DIV).
- `TICK_STEP`, default 2: period decrement per level.
- `LEVEL_PIPES`, default 8: pipes spawned per level-up.
- `PIPE_W`, default 2: pipe width in columns (≥ 1).
- `SPACING`, default 6: empty columns between pipes (≥ 1).
- `GAP_H`, default 4: gap height in rows (1–8).

Ports:
- `clk` in 1: system clock; only clock.
- `RST` in 1: reset, synchronous, active-high.
- `go` in 1: start request, level-sensitive, sampled on each edge.
- `Over` in 1: game over, level-sensitive.
- `shift` out 1: one-cycle pulse; the downstream register shifts on this edge.
- `newCol` out 16: column to insert; bit i = row i; 1 = pipe lit. Valid whenever `shift` = 1.
- `spawn` out 1: high with `shift` on the first column of each new pipe.
- `gapTop` out 4: top row of the current pipe's gap.
- `level` out 4: difficulty level, saturates at 15.
- `running` out 1: high in RUN.

## Operation
- All outputs are registered. On an edge with `RST`=1:
  - state = IDLE; `shift` = `spawn` = 0; `newCol` = 16'h0000; `gapTop` = 0; `level` = 0; `running` = 0.
  - Internal: tick counter = 0, column counter = 0, pipe counter = 0, period = TICK_DIV, LFSR = 8'hA5.
  - `RST` overrides all other inputs in all states, including mid-RUN.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left every cycle outside reset, in all states. The all-zero state is unreachable.
- FSM:
  - IDLE: `Over`=1 → OVER (Over wins over go); else `go`=1 → RUN; else stay.
  - RUN: `Over`=1 → OVER; else stay.
  - OVER: stay until `RST`. `go` is ignored.
- Entering RUN clears the tick counter and the column counter.
- In RUN the tick counter counts 0..period−1. At period−1 it wraps to 0, and on that edge the block registers `shift`=1 and a new `newCol`.
- Column counter c, taking values 0..PIPE_W+SPACING−1, advances on each shift and wraps:
  - c = 0: latch gap g from LFSR[3:0]. If LFSR[3:0] > 16−GAP_H, g = LFSR[3:0] − 8.
  - c = 0: `gapTop` ← g, `spawn` = 1, pipe counter +1.
  - c < PIPE_W: `newCol` = all ones except bits g..g+GAP_H−1 = 0.
  - otherwise: `newCol` = 16'h0000.
- Level-up: when the pipe counter reaches LEVEL_PIPES it resets to 0.
  - `level` increments, saturating at 15.
  - period ← max(period − TICK_STEP, TICK_MIN).
  - The new period applies from the next tick-counter wrap.
- OVER freezes:
  - No further `shift` or `spawn`.
  - `newCol`, `gapTop`, `level` and period hold their values.
  - `running` = 0.

## Timing
- `shift` and `spawn` are never high in consecutive cycles.
- The go edge (IDLE→RUN) is E0. The first `shift` is high during the cycle after edge E0+period, then every period cycles after that.
- `newCol` and `gapTop` change only on edges that raise `shift`.
- `Over` sampled on edge E → state is OVER after E.
  - A `shift` registered on E itself is suppressed: `shift` is forced to 0 on entry to OVER.
  - Hence no `shift` occurs in the cycle after E or later.
- If `Over` and a tick wrap coincide, no shift is issued.
- The pipe counter and level update on the same edge as the `spawn` that completes the count.
- Over-to-frozen latency: 1 cycle. Go-to-first-shift latency: period+1 edges.
- `RST` during RUN: all outputs reach reset values one edge later. Operation restarts only after a new `go`.

## Test plan
- Reset then idle: `RST`=1 for one edge, hold `go`=0 for 50 cycles → `shift`=0 throughout; `newCol`=0, `level`=0, `running`=0.
- Start timing (TICK_DIV=4, PIPE_W=2, SPACING=6): assert `go` at edge E0 → `shift` high in the cycles after E0+4, E0+8, E0+12, ….
  - `spawn` coincides with shifts 1, 9, 17.
  - Shifts 1–2 carry the pipe pattern; shifts 3–8 carry 16'h0000.
- Gap check: for 64 spawns compare `gapTop` to a reference LFSR model.
  - gapTop ≤ 16−GAP_H.
  - `newCol` has exactly GAP_H zero bits, contiguous at gapTop.
- Difficulty (TICK_DIV=8, TICK_STEP=2, TICK_MIN=4, LEVEL_PIPES=2):
  - Shift spacing is 8 cycles at level 0, 6 after the 2nd spawn, and 4 after the 4th.
  - Spacing stays 4 after the 6th spawn while `level` keeps incrementing (3).
- Over mid-run: raise `Over` on the same edge a tick wraps → no `shift` that cycle or after, `running`=0.
  - `newCol` holds its last value for 100 cycles.
  - `go` pulses are ignored; `RST` returns to IDLE.
- Simultaneous `go` and `Over` in IDLE → state OVER, no shift ever. `RST` pulse mid-RUN → reset values next cycle, then a `go` restarts with period = TICK_DIV.
